fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch-stage sequencer for the instruction memory. Owns the program counter and drives the word index into the instruction memory. Selects the next PC from these sources: sequential, branch/jump redirect, exception vector, or ERET return. Holds redirects that arrive while the pipeline is stalled and flags instruction-fetch address errors (AdEL) to the exception logic.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_4180, handler entry address.
IM_BASE, 32'h0000_3000, first legal fetch address.
IM_WORDS, 4096, instruction memory depth in words; the legal range is IM_BASE .. IM_BASE+4*IM_WORDS-1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  hazard stall from the decode stage; hold the PC.
br_taken  input  1  branch/jump resolved taken this cycle.
br_target  input  32  redirect target, valid when br_taken=1.
exc_req  input  1  exception/interrupt taken; flush to the vector.
eret_req  input  1  ERET retiring; return to epc.
epc  input  32  exception return address from CP0.
pc  output  32  current fetch address (register).
im_addr  output  12  pc[13:2]; drives the instruction memory address port.
fetch_valid  output  1  the fetched word at pc is a real instruction.
fetch_adel  output  1  the current pc is misaligned or out of range.
redirect_pend  output  1  a redirect was captured during stall and is still waiting.

Behaviour:
- Reset (reset=0, async):
  - pc=PC_RESET, state=BOOT, fetch_valid=0, redirect_pend=0, pend_target=0.
- States:
  - BOOT: one cycle after reset release, fetch_valid=0, pc holds, then go to RUN. exc_req and eret_req are ignored in BOOT.
  - RUN: normal fetch.
  - PEND: a redirect is held.
- Next-PC priority, evaluated every edge in RUN and PEND (highest first):
  1. exc_req: pc<=EXC_VECTOR; clear pending; go to RUN. Applies even when stall=1.
  2. eret_req: pc<=epc; clear pending; go to RUN. Applies even when stall=1.
  3. stall=1 in RUN with br_taken=1: pend_target<=br_target; pc holds; go to PEND.
  4. stall=1 otherwise: pc holds. In PEND, a later br_taken is ignored (the first capture wins).
  5. stall=0 in PEND: pc<=pend_target; go to RUN. A concurrent br_taken is ignored because the pending redirect is older.
  6. stall=0 in RUN with br_taken=1: pc<=br_target.
  7. Otherwise: pc<=pc+4, which wraps modulo 2^32.
- redirect_pend=1 exactly while state=PEND.
- fetch_valid=1 in RUN and PEND, and 0 in BOOT.
- im_addr=pc[13:2] combinationally; the memory itself subtracts the base.
- fetch_adel (combinational from pc):
  - Asserts when pc[1:0]!=0, pc<IM_BASE, or pc>=IM_BASE+4*IM_WORDS.
  - fetch_valid stays 1 while fetch_adel=1; downstream converts the word to a NOP and raises AdEL.
  - The sequencer does not self-redirect; it waits for exc_req.
- Latency: a redirect is visible on pc one cycle after the request edge. Combinational paths are limited to im_addr and fetch_adel; no other comb path runs from inputs to outputs.
- Reset mid-operation clears PEND and any captured target immediately.

Test Plan:
- Reset low then release; no requests for 4 cycles → BOOT cycle shows pc=0x3000 with fetch_valid=0. pc then steps 0x3000, 0x3004, 0x3008, 0x300C with fetch_valid=1 and im_addr=0xC00, 0xC01, 0xC02, 0xC03.
- At pc=0x3010, stall=1 for 2 cycles, then 0 → pc holds at 0x3010 for 2 cycles, then becomes 0x3014.
- At pc=0x3020, stall=1 and br_taken=1 with target 0x3100; next cycle br_taken=1 with target 0x3200 while still stalled; then stall=0 → redirect_pend=1 during the stall, pc holds at 0x3020, then pc=0x3100. Target 0x3200 is dropped.
- In PEND, assert exc_req → pc=0x4180 next cycle, redirect_pend=0, and pend_target is discarded.
- eret_req with epc=0x3044 during stall=1 → pc=0x3044 next cycle.
- br_target=0x3002 → fetch_adel=1 and fetch_valid=1. Then br_target=0x7000 → fetch_adel=1. Then br_target=0x6FFC → fetch_adel=0 and im_addr=0xBFF.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Purpose: fetch-stage PC sequencer; picks next PC from sequential, branch, exception vector or ERET.
// Latency: one cycle from request edge to new pc; im_addr/fetch_adel are combinational from pc.
// Backpressure: stall holds pc; a branch seen during stall is parked and replayed on release.
//
// Ports:
//   clk, reset         rising-edge clock, async active-low reset
//   stall              hold pc this cycle
//   br_taken/br_target branch or jump redirect
//   exc_req            flush to EXC_VECTOR (wins over everything, even stall)
//   eret_req/epc       return from exception (wins over stall)
//   pc, im_addr        fetch address and its word index into instruction memory
//   fetch_valid        pc holds a real fetch (low only in the boot cycle)
//   fetch_adel         pc misaligned or outside instruction memory
//   redirect_pend      a branch captured during stall is still waiting
module fetch_ctrl #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int unsigned IM_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [11:0] im_addr,
    output logic        fetch_valid,
    output logic        fetch_adel,
    output logic        redirect_pend
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // One past the last legal byte address; 33 bits so the sum cannot wrap.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] pend_target, pend_target_nxt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= PC_RESET;
            pend_target <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    // Next-state / next-PC selection
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pend_target_nxt = pend_target;
        case (state)
            BOOT: begin
                // Requests are ignored during the boot cycle; pc stays at reset value.
                state_nxt = RUN;
            end
            RUN, PEND: begin
                if (exc_req) begin
                    pc_nxt          = EXC_VECTOR;
                    pend_target_nxt = 32'h0;
                    state_nxt       = RUN;
                end else if (eret_req) begin
                    pc_nxt          = epc;
                    pend_target_nxt = 32'h0;
                    state_nxt       = RUN;
                end else if (stall) begin
                    // Only the first branch during a stall is kept; later ones are dropped.
                    if (state == RUN && br_taken) begin
                        pend_target_nxt = br_target;
                        state_nxt       = PEND;
                    end
                end else if (state == PEND) begin
                    // The parked redirect is older than any branch arriving now.
                    pc_nxt          = pend_target;
                    pend_target_nxt = 32'h0;
                    state_nxt       = RUN;
                end else if (br_taken) begin
                    pc_nxt = br_target;
                end else begin
                    pc_nxt = pc + 32'd4;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Outputs
    always_comb begin
        fetch_valid   = (state != BOOT);
        redirect_pend = (state == PEND);
        im_addr       = pc[13:2];
        // Fetch continues through an address error; the exception logic decides.
        fetch_adel    = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_LIMIT);
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'h0;
    logic [31:0] pc;
    logic [11:0] im_addr;
    logic        fetch_valid;
    logic        fetch_adel;
    logic        redirect_pend;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .pc           (pc),
        .im_addr      (im_addr),
        .fetch_valid  (fetch_valid),
        .fetch_adel   (fetch_adel),
        .redirect_pend(redirect_pend)
    );

    always #5 clk = ~clk;

    // Behavioural model: pc as a number, boot as a flag, parked redirects as a queue.
    logic [31:0] m_pc = 32'h3000;
    bit          m_booting = 1'b1;
    logic [31:0] m_pendq[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 32'h3000;
            m_booting = 1'b1;
            m_pendq.delete();
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (exc_req) begin
            m_pc = 32'h4180;
            m_pendq.delete();
        end else if (eret_req) begin
            m_pc = epc;
            m_pendq.delete();
        end else if (stall) begin
            if (br_taken && m_pendq.size() == 0) m_pendq.push_back(br_target);
        end else if (m_pendq.size() != 0) begin
            m_pc = m_pendq.pop_front();
        end else if (br_taken) begin
            m_pc = br_target;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (checking) begin
            longint unsigned a;
            bit exp_adel;
            a = longint'(m_pc);
            exp_adel = (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 4 * 4096);
            chk("pc", pc, m_pc);
            chk("im_addr", 32'(im_addr), 32'((a / 4) % 4096));
            chk("fetch_valid", 32'(fetch_valid), 32'(!m_booting));
            chk("fetch_adel", 32'(fetch_adel), 32'(exp_adel));
            chk("redirect_pend", 32'(redirect_pend), 32'(m_pendq.size() != 0));
        end
    end

    // Advance one clock edge and settle just past the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t,
                         input logic e, input logic r, input logic [31:0] ep);
        stall = s; br_taken = b; br_target = t; exc_req = e; eret_req = r; epc = ep;
    endtask

    initial begin
        // Reset and boot
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_valid", 32'(fetch_valid), 32'h0);
        chk("rst_pend", 32'(redirect_pend), 32'h0);
        checking = 1'b1;
        reset = 1'b1;
        chk("boot_valid", 32'(fetch_valid), 32'h0);
        tick(); chk("run0_pc", pc, 32'h3000); chk("run0_im", 32'(im_addr), 32'hC00);
        chk("run0_valid", 32'(fetch_valid), 32'h1);
        tick(); chk("run1_im", 32'(im_addr), 32'hC01);
        tick(); chk("run2_im", 32'(im_addr), 32'hC02);
        tick(); chk("run3_pc", pc, 32'h300C); chk("run3_im", 32'(im_addr), 32'hC03);
        tick(); chk("run4_pc", pc, 32'h3010);

        // Plain stall for two cycles
        drive(1, 0, 0, 0, 0, 0);
        tick(); chk("stall1_pc", pc, 32'h3010);
        tick(); chk("stall2_pc", pc, 32'h3010);
        drive(0, 0, 0, 0, 0, 0);
        tick(); chk("unstall_pc", pc, 32'h3014);
        repeat (3) tick();
        chk("at3020", pc, 32'h3020);

        // Branch parked during stall; second branch dropped
        drive(1, 1, 32'h3100, 0, 0, 0);
        tick(); chk("park_pend", 32'(redirect_pend), 32'h1); chk("park_pc", pc, 32'h3020);
        drive(1, 1, 32'h3200, 0, 0, 0);
        tick(); chk("park2_pc", pc, 32'h3020);
        drive(0, 0, 0, 0, 0, 0);
        tick(); chk("replay_pc", pc, 32'h3100); chk("replay_pend", 32'(redirect_pend), 32'h0);

        // Exception in PEND discards the parked target
        drive(1, 1, 32'h3300, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 0, 0);
        tick(); chk("exc_pc", pc, 32'h4180); chk("exc_pend", 32'(redirect_pend), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        tick(); chk("exc_next", pc, 32'h4184);

        // ERET under stall, then exception beats ERET
        drive(1, 0, 0, 0, 1, 32'h3044);
        tick(); chk("eret_pc", pc, 32'h3044);
        drive(0, 0, 0, 0, 0, 0);
        tick(); chk("eret_next", pc, 32'h3048);
        drive(0, 0, 0, 1, 1, 32'h3044);
        tick(); chk("exc_over_eret", pc, 32'h4180);

        // Parked redirect beats a concurrent branch on release
        drive(1, 1, 32'h3100, 0, 0, 0);
        tick();
        drive(0, 1, 32'h3500, 0, 0, 0);
        tick(); chk("old_wins", pc, 32'h3100);

        // Address errors and boundaries
        drive(0, 1, 32'h3002, 0, 0, 0);
        tick(); chk("mis_adel", 32'(fetch_adel), 32'h1); chk("mis_valid", 32'(fetch_valid), 32'h1);
        drive(0, 1, 32'h7000, 0, 0, 0);
        tick(); chk("hi_adel", 32'(fetch_adel), 32'h1);
        drive(0, 1, 32'h6FFC, 0, 0, 0);
        tick(); chk("top_adel", 32'(fetch_adel), 32'h0); chk("top_im", 32'(im_addr), 32'hBFF);
        drive(0, 0, 0, 0, 0, 0);
        tick(); chk("seq_over_top", pc, 32'h7000); chk("seq_over_adel", 32'(fetch_adel), 32'h1);
        drive(0, 1, 32'h2FFC, 0, 0, 0);
        tick(); chk("lo_adel", 32'(fetch_adel), 32'h1);
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick(); chk("wrap_pc", pc, 32'h0);

        // Reset mid-PEND, requests ignored in boot
        drive(1, 1, 32'h3600, 0, 0, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h3000);
        chk("mid_rst_pend", 32'(redirect_pend), 32'h0);
        chk("mid_rst_valid", 32'(fetch_valid), 32'h0);
        drive(0, 1, 32'h3700, 1, 1, 32'h3800);
        @(negedge clk); #1;
        reset = 1'b1;
        tick(); chk("boot_ignore_pc", pc, 32'h3000);
        drive(0, 0, 0, 0, 0, 0);
        tick(); chk("after_boot_pc", pc, 32'h3004);
        tick();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
